// File: rtl/signed_peak_detect_if.sv
// Sample-in / window-result-out bundle for signed_peak_detect.
// The master drives samples; the slave (the detector) returns results.
interface signed_peak_detect_if #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = 4
);
  logic             clr;
  logic             din_vld;
  logic [WIDTH-1:0] din;
  logic             busy;
  logic             peak_vld;
  logic [WIDTH-1:0] max_out;
  logic [WIDTH-1:0] min_out;
  logic [CNT_W-1:0] max_idx;
  logic [CNT_W-1:0] min_idx;

  modport master (
    output clr, din_vld, din,
    input  busy, peak_vld, max_out, min_out, max_idx, min_idx
  );

  modport slave (
    input  clr, din_vld, din,
    output busy, peak_vld, max_out, min_out, max_idx, min_idx
  );
endinterface

// File: rtl/signed_peak_detect.sv
// Windowed signed max/min detector: reports the extremes of every WIN_LEN accepted samples
// (with their positions) as a one-cycle peak_vld pulse one cycle after the last sample.
module signed_peak_detect #(
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned WIN_LEN = 16,
  parameter int unsigned CNT_W   = 4
) (
  input logic                sys_clk,
  input logic                sys_rst_n,
  signed_peak_detect_if.slave bus
);

  if (WIDTH < 2 || WIN_LEN < 2 || (WIN_LEN - 1) >= (1 << CNT_W)) begin : g_param_check
    $error("signed_peak_detect: unsupported WIDTH/WIN_LEN/CNT_W combination");
  end

  localparam logic [CNT_W-1:0] LastCnt = CNT_W'(WIN_LEN - 1);

  typedef enum logic [0:0] {StEmpty, StAcc} state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] run_max_q, run_max_d, run_min_q, run_min_d;
  logic [CNT_W-1:0] run_max_idx_q, run_max_idx_d, run_min_idx_q, run_min_idx_d;
  logic [WIDTH-1:0] max_out_q, max_out_d, min_out_q, min_out_d;
  logic [CNT_W-1:0] max_idx_q, max_idx_d, min_idx_q, min_idx_d;
  logic             peak_vld_q, peak_vld_d;

  logic             accept;
  logic             new_max, new_min;
  logic [WIDTH-1:0] cand_max, cand_min;
  logic [CNT_W-1:0] cand_max_idx, cand_min_idx;

  // Flipping the sign bit maps two's-complement order onto unsigned order.
  function automatic logic [WIDTH-1:0] key(input logic [WIDTH-1:0] d);
    return {~d[WIDTH-1], d[WIDTH-2:0]};
  endfunction

  assign accept  = bus.din_vld & ~bus.clr;
  // Strict compares so the earliest occurrence of a tied value keeps its index.
  assign new_max = key(bus.din) > key(run_max_q);
  assign new_min = key(bus.din) < key(run_min_q);

  assign cand_max     = new_max ? bus.din : run_max_q;
  assign cand_max_idx = new_max ? cnt_q   : run_max_idx_q;
  assign cand_min     = new_min ? bus.din : run_min_q;
  assign cand_min_idx = new_min ? cnt_q   : run_min_idx_q;

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    run_max_d     = run_max_q;
    run_min_d     = run_min_q;
    run_max_idx_d = run_max_idx_q;
    run_min_idx_d = run_min_idx_q;
    max_out_d     = max_out_q;
    min_out_d     = min_out_q;
    max_idx_d     = max_idx_q;
    min_idx_d     = min_idx_q;
    peak_vld_d    = 1'b0;

    if (bus.clr) begin
      state_d = StEmpty;
      cnt_d   = '0;
    end else if (accept) begin
      unique case (state_q)
        StEmpty: begin
          run_max_d     = bus.din;
          run_min_d     = bus.din;
          run_max_idx_d = '0;
          run_min_idx_d = '0;
          cnt_d         = CNT_W'(1);
          state_d       = StAcc;
        end
        StAcc: begin
          if (cnt_q == LastCnt) begin
            max_out_d  = cand_max;
            min_out_d  = cand_min;
            max_idx_d  = cand_max_idx;
            min_idx_d  = cand_min_idx;
            peak_vld_d = 1'b1;
            cnt_d      = '0;
            state_d    = StEmpty;
          end else begin
            run_max_d     = cand_max;
            run_min_d     = cand_min;
            run_max_idx_d = cand_max_idx;
            run_min_idx_d = cand_min_idx;
            cnt_d         = cnt_q + CNT_W'(1);
          end
        end
        default: state_d = StEmpty;
      endcase
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q       <= StEmpty;
      cnt_q         <= '0;
      run_max_q     <= '0;
      run_min_q     <= '0;
      run_max_idx_q <= '0;
      run_min_idx_q <= '0;
      max_out_q     <= '0;
      min_out_q     <= '0;
      max_idx_q     <= '0;
      min_idx_q     <= '0;
      peak_vld_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      run_max_q     <= run_max_d;
      run_min_q     <= run_min_d;
      run_max_idx_q <= run_max_idx_d;
      run_min_idx_q <= run_min_idx_d;
      max_out_q     <= max_out_d;
      min_out_q     <= min_out_d;
      max_idx_q     <= max_idx_d;
      min_idx_q     <= min_idx_d;
      peak_vld_q    <= peak_vld_d;
    end
  end

  assign bus.busy     = (state_q == StAcc);
  assign bus.peak_vld = peak_vld_q;
  assign bus.max_out  = max_out_q;
  assign bus.min_out  = min_out_q;
  assign bus.max_idx  = max_idx_q;
  assign bus.min_idx  = min_idx_q;

endmodule

// File: tb/tb_signed_peak_detect.sv
// Directed bench for signed_peak_detect with WIDTH=8, WIN_LEN=4, CNT_W=2.
module tb_signed_peak_detect;

  localparam int unsigned WIDTH   = 8;
  localparam int unsigned WIN_LEN = 4;
  localparam int unsigned CNT_W   = 2;

  logic sys_clk;
  logic sys_rst_n;

  signed_peak_detect_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) bus ();

  signed_peak_detect #(
    .WIDTH  (WIDTH),
    .WIN_LEN(WIN_LEN),
    .CNT_W  (CNT_W)
  ) dut (
    .sys_clk  (sys_clk),
    .sys_rst_n(sys_rst_n),
    .bus      (bus.slave)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  typedef struct {
    logic [7:0] s [4];
    logic [7:0] max_v;
    logic [7:0] min_v;
    logic [1:0] max_i;
    logic [1:0] min_i;
  } vec_t;

  vec_t vecs [6];
  int   total = 0;
  int   bad   = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  // Drive one cycle of inputs, then land 1 time unit past the active edge.
  task automatic apply(input logic vld, input logic clr, input logic [7:0] d);
    bus.din_vld = vld;
    bus.clr     = clr;
    bus.din     = d;
    @(posedge sys_clk);
    #1;
  endtask

  task automatic chk_result(input string tag, input logic [7:0] mx, input logic [7:0] mn,
                            input logic [1:0] mxi, input logic [1:0] mni);
    chk({tag, " max_out"}, 32'(bus.max_out), 32'(mx));
    chk({tag, " min_out"}, 32'(bus.min_out), 32'(mn));
    chk({tag, " max_idx"}, 32'(bus.max_idx), 32'(mxi));
    chk({tag, " min_idx"}, 32'(bus.min_idx), 32'(mni));
  endtask

  // Back-to-back window: din_vld held for all four samples.
  task automatic run_vec(input int k);
    string tag;
    tag = $sformatf("vec%0d", k);
    for (int i = 0; i < 4; i++) begin
      apply(1'b1, 1'b0, vecs[k].s[i]);
      if (i < 3) begin
        chk({tag, " peak_vld early"}, 32'(bus.peak_vld), 32'd0);
        chk({tag, " busy mid"}, 32'(bus.busy), 32'd1);
      end else begin
        chk({tag, " peak_vld"}, 32'(bus.peak_vld), 32'd1);
        chk({tag, " busy end"}, 32'(bus.busy), 32'd0);
        chk_result(tag, vecs[k].max_v, vecs[k].min_v, vecs[k].max_i, vecs[k].min_i);
      end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{s: '{8'h05, 8'h80, 8'h7F, 8'hFF}, max_v: 8'h7F, min_v: 8'h80, max_i: 2, min_i: 1};
    vecs[1] = '{s: '{8'hF0, 8'hFE, 8'h81, 8'hC0}, max_v: 8'hFE, min_v: 8'h81, max_i: 1, min_i: 2};
    vecs[2] = '{s: '{8'h10, 8'h10, 8'h10, 8'h10}, max_v: 8'h10, min_v: 8'h10, max_i: 0, min_i: 0};
    vecs[3] = '{s: '{8'h00, 8'h01, 8'h02, 8'h03}, max_v: 8'h03, min_v: 8'h00, max_i: 3, min_i: 0};
    vecs[4] = '{s: '{8'h04, 8'h05, 8'h06, 8'h07}, max_v: 8'h07, min_v: 8'h04, max_i: 3, min_i: 0};
    vecs[5] = '{s: '{8'h7F, 8'h80, 8'h80, 8'h7F}, max_v: 8'h7F, min_v: 8'h80, max_i: 0, min_i: 1};

    bus.din_vld = 1'b0;
    bus.clr     = 1'b0;
    bus.din     = '0;
    sys_rst_n   = 1'b0;
    repeat (2) @(posedge sys_clk);
    #1;
    chk("reset busy", 32'(bus.busy), 32'd0);
    chk("reset peak_vld", 32'(bus.peak_vld), 32'd0);
    chk_result("reset", 8'h00, 8'h00, 2'd0, 2'd0);
    sys_rst_n = 1'b1;
    apply(1'b0, 1'b0, 8'h00);

    // All windows back-to-back, no idle cycle between them.
    for (int k = 0; k < 6; k++) run_vec(k);
    apply(1'b0, 1'b0, 8'h00);
    chk("peak_vld one cycle", 32'(bus.peak_vld), 32'd0);
    chk_result("hold", 8'h7F, 8'h80, 2'd0, 2'd1);

    // Idle gaps inside a window freeze state.
    apply(1'b1, 1'b0, 8'hA0);
    apply(1'b0, 1'b0, 8'h55);
    apply(1'b0, 1'b0, 8'h55);
    chk("gap busy", 32'(bus.busy), 32'd1);
    apply(1'b1, 1'b0, 8'h30);
    apply(1'b0, 1'b0, 8'h00);
    apply(1'b1, 1'b0, 8'hA0);
    apply(1'b1, 1'b0, 8'hE0);
    chk("gap peak_vld", 32'(bus.peak_vld), 32'd1);
    chk_result("gap", 8'h30, 8'hA0, 2'd1, 2'd0);

    // clr after two samples drops the partial window and its own sample.
    apply(1'b1, 1'b0, 8'h50);
    apply(1'b1, 1'b0, 8'h60);
    apply(1'b1, 1'b1, 8'h7E);
    chk("clr busy", 32'(bus.busy), 32'd0);
    chk("clr peak_vld", 32'(bus.peak_vld), 32'd0);
    chk_result("clr hold", 8'h30, 8'hA0, 2'd1, 2'd0);
    for (int i = 1; i <= 4; i++) begin
      apply(1'b1, 1'b0, 8'(i));
      chk($sformatf("post-clr peak_vld s%0d", i), 32'(bus.peak_vld), 32'(i == 4));
    end
    chk_result("post-clr", 8'h04, 8'h01, 2'd3, 2'd0);

    // clr coinciding with the last sample discards the window.
    apply(1'b1, 1'b0, 8'h11);
    apply(1'b1, 1'b0, 8'h22);
    apply(1'b1, 1'b0, 8'h33);
    apply(1'b1, 1'b1, 8'h44);
    chk("clr-last peak_vld", 32'(bus.peak_vld), 32'd0);
    chk("clr-last busy", 32'(bus.busy), 32'd0);
    chk_result("clr-last hold", 8'h04, 8'h01, 2'd3, 2'd0);

    // Asynchronous reset mid-window, away from any clock edge.
    apply(1'b1, 1'b0, 8'h09);
    apply(1'b1, 1'b0, 8'h08);
    apply(1'b0, 1'b0, 8'h00);
    #2;
    sys_rst_n = 1'b0;
    #1;
    chk("async rst busy", 32'(bus.busy), 32'd0);
    chk("async rst peak_vld", 32'(bus.peak_vld), 32'd0);
    chk_result("async rst", 8'h00, 8'h00, 2'd0, 2'd0);
    @(posedge sys_clk);
    #2;
    sys_rst_n = 1'b1;
    apply(1'b0, 1'b0, 8'h00);
    apply(1'b1, 1'b0, 8'hFC);
    apply(1'b0, 1'b0, 8'h00);
    apply(1'b1, 1'b0, 8'h02);
    apply(1'b1, 1'b0, 8'hFB);
    chk("post-rst peak_vld early", 32'(bus.peak_vld), 32'd0);
    apply(1'b1, 1'b0, 8'h02);
    chk("post-rst peak_vld", 32'(bus.peak_vld), 32'd1);
    chk_result("post-rst", 8'h02, 8'hFB, 2'd1, 2'd2);
    apply(1'b0, 1'b0, 8'h00);
    chk("post-rst pulse end", 32'(bus.peak_vld), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
